a_pingpong_buf: RTL and testbench
=================================

// Module: a_pingpong_buf
// PURPOSE
//  Parametrised multi-bank operand-A staging buffer between the A-load engine and the systolic array.
//  - Loader fills one bank while the array drains another. Banks rotate round-robin.
//  - Per-bank EMPTY/FULL ownership with valid/ready handshake on write and explicit release on read.
//  - Registered read with 1-cycle latency. Synchronous flush.
//  - Replaces the fixed 2-bank, always-valid, combinational-read A buffer.
// PARAMETERS
//  DATA_W   `SARRAY_LOAD_WIDTH   width of one row/column word
//  DEPTH    64                   words per bank
//  NBANK    2                    number of banks (>=1)
//  ADDR_W   $clog2(DEPTH)        localparam, word address width (== `TMMA_CNT_WIDTH at defaults)
//  BID_W    max(1,$clog2(NBANK)) localparam, bank pointer width
// PORTS
//  clk             in   1       clock, rising edge
//  rst_n           in   1       asynchronous, active-low reset
//  flush_i         in   1       synchronous clear of all banks and pointers
//  wr_valid_i      in   1       write request
//  wr_ready_o      out  1       bank[wr_ptr] is EMPTY; write accepted on valid&ready
//  wr_addr_i       in   ADDR_W  word address within current write bank
//  wr_data_i       in   DATA_W  write data
//  wr_last_i       in   1       with an accepted write: commit bank (-> FULL), advance wr_ptr
//  rd_avail_o      out  1       bank[rd_ptr] is FULL and readable
//  rd_valid_i      in   1       read request; honoured only when rd_avail_o=1
//  rd_addr_i       in   ADDR_W  word address within current read bank
//  rd_last_i       in   1       with an honoured read: release bank (-> EMPTY), advance rd_ptr
//  rd_ret_valid_o  out  1       read data valid, 1 cycle after honoured read
//  rd_ret_data_o   out  DATA_W  read data
//  bank_full_o     out  NBANK   per-bank FULL bitmap (bit i = bank i)
// BEHAVIOUR
//  - Reset: all banks EMPTY, wr_ptr=rd_ptr=0.
//    Outputs: wr_ready_o=1, rd_avail_o=0, rd_ret_valid_o=0, rd_ret_data_o=0, bank_full_o=0.
//    RAM contents are not reset.
//  - Per-bank state, 1 bit: EMPTY->FULL on accepted write with wr_last_i to that bank.
//    FULL->EMPTY on honoured read with rd_last_i from that bank. No other transitions except flush/reset.
//  - Write: when wr_valid_i & wr_ready_o, mem[wr_ptr][wr_addr_i] <= wr_data_i.
//    Writes are in any address order. wr_valid_i while !wr_ready_o is dropped (no storage, no state change).
//  - Read: honoured when rd_valid_i & rd_avail_o.
//    Next cycle: rd_ret_valid_o=1 and rd_ret_data_o=mem[rd_ptr_at_request][rd_addr_i].
//    Unhonoured read: rd_ret_valid_o=0 next cycle, rd_ret_data_o holds its last value.
//  - Pointers: wr_ptr/rd_ptr increment mod NBANK; wrap from NBANK-1 to 0.
//    A non-power-of-2 NBANK wraps explicitly.
//  - Ready/avail are decoded from registered state only; there is no same-cycle bypass:
//    - Release and write to the same bank in one cycle (NBANK=1, or all banks FULL): write is not accepted.
//      wr_ready_o rises the following cycle.
//    - Commit and read of the same bank in one cycle: read is not honoured. rd_avail_o rises next cycle.
//    - Commit on bank X and release on bank Y (X!=Y) in the same cycle: both take effect.
//  - Data hazard: a FULL bank is never writable, so read-during-write to the same bank cannot occur.
//  - Flush: flush_i has priority over everything; the concurrent write and read are dropped.
//    Next cycle: all EMPTY, pointers 0, rd_ret_valid_o=0.
//    A read honoured in the cycle before flush still returns its data in the flush cycle.
//  - Async reset mid-operation: immediate return to reset values; in-flight read return is lost.
//  - All-banks-FULL: wr_ready_o=0 (loader back-pressured). All-EMPTY: rd_avail_o=0 (array stalls).
// STRUCTURE
//  - Package gnpu_buf_pkg:
//    - typedef buf_state_e {BUF_EMPTY, BUF_FULL}
//    - function to compute pointer wrap for generic NBANK
//    - defaults A_BUF_DEPTH=64, A_BUF_NBANK=2, shared with the future b_pingpong_buf.
//  - Sub-module buf_bank_ram: 1W1R, synchronous-read, DEPTH x DATA_W, no reset.
//    Instantiated NBANK times via generate; its wr_en/rd_en are decoded from wr_ptr/rd_ptr.
//  - Top level keeps state bits, pointers, the read-bank select register and the output mux/register.
// TESTING
//  1. Reset, then idle -> wr_ready_o=1, rd_avail_o=0, bank_full_o=2'b00, rd_ret_valid_o=0.
//  2. Write addr 0..63 data=addr+0x100, last on 63 -> bank_full_o=2'b01, rd_avail_o=1.
//     Read addr 5 -> next cycle rd_ret_valid_o=1, data=0x105.
//  3. Fill bank0 and bank1 (NBANK=2), then a 3rd write -> wr_ready_o=0 and the write is dropped.
//     Release bank0 via rd_last -> wr_ready_o=1 the next cycle; the 3rd fill lands in bank0.
//  4. NBANK=1: rd_last on 63 and wr_valid in the same cycle -> write not accepted.
//     Retried next cycle -> accepted, and the new data reads back.
//  5. rd_valid_i with rd_avail_o=0 -> rd_ret_valid_o=0 and rd_ret_data_o unchanged.
//     Random fill/drain of NBANK=3 for 1000 banks -> scoreboard matches, pointers wrap 2->0.
//  6. flush_i together with wr_last and rd_valid -> next cycle bank_full_o=0, pointers 0,
//     rd_ret_valid_o=0. Async rst_n pulse mid-fill -> outputs return to reset values immediately.

Source files
------------

// File: rtl/gnpu_buf_pkg.sv
// Shared types and defaults for the GNPU operand staging buffers
// (A side today, B side later).
package gnpu_buf_pkg;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

  localparam int A_BUF_DATA_W = 32;
  localparam int A_BUF_DEPTH = 64;
  localparam int A_BUF_NBANK = 2;

  // A single-bank buffer still carries a 1-bit pointer that always stays at 0.
  function automatic int bid_width(input int nbank);
    return (nbank > 1) ? $clog2(nbank) : 1;
  endfunction

  // Round-robin pointer increment; wraps explicitly so any NBANK works.
  function automatic int unsigned bank_ptr_inc(input int unsigned ptr,
                                               input int unsigned nbank);
    return (ptr >= nbank - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/buf_bank_ram.sv
// One staging bank: 1 write port, 1 synchronous read port, DEPTH x DATA_W.
// Memory and read register are left unreset.
module buf_bank_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_d;
  logic [DATA_W-1:0] rd_data_q;

  // The read register only loads on rd_en, so the last word is held otherwise.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en_i) rd_data_d = mem[rd_addr_i];
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
    rd_data_q <= rd_data_d;
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/a_pingpong_buf.sv
// Multi-bank operand-A staging buffer: loader fills one bank while the
// systolic array drains another, with per-bank EMPTY/FULL ownership.
module a_pingpong_buf
  import gnpu_buf_pkg::*;
#(
  parameter  int DATA_W = A_BUF_DATA_W,
  parameter  int DEPTH  = A_BUF_DEPTH,
  parameter  int NBANK  = A_BUF_NBANK,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int BID_W  = bid_width(NBANK)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              wr_last_i,
  output logic              rd_avail_o,
  input  logic              rd_valid_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic              rd_last_i,
  output logic              rd_ret_valid_o,
  output logic [DATA_W-1:0] rd_ret_data_o,
  output logic [NBANK-1:0]  bank_full_o
);

  buf_state_e       bank_st_q [NBANK];
  buf_state_e       bank_st_d [NBANK];
  logic [BID_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [BID_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [BID_W-1:0] rd_sel_q, rd_sel_d;
  logic             rd_ret_valid_q, rd_ret_valid_d;
  logic             have_data_q, have_data_d;
  logic             wr_fire, rd_fire;
  logic [DATA_W-1:0] ram_rdata [NBANK];

  // Handshakes look only at registered state, so a bank released (or
  // committed) this cycle cannot be reused until the next one.
  assign wr_ready_o = (bank_st_q[wr_ptr_q] == BUF_EMPTY);
  assign rd_avail_o = (bank_st_q[rd_ptr_q] == BUF_FULL);
  assign wr_fire    = wr_valid_i && wr_ready_o && !flush_i;
  assign rd_fire    = rd_valid_i && rd_avail_o && !flush_i;

  always_comb begin
    bank_st_d      = bank_st_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    rd_sel_d       = rd_sel_q;
    rd_ret_valid_d = rd_fire;
    have_data_d    = have_data_q || rd_fire;
    if (flush_i) begin
      for (int i = 0; i < NBANK; i++) bank_st_d[i] = BUF_EMPTY;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_fire && wr_last_i) begin
        bank_st_d[wr_ptr_q] = BUF_FULL;
        wr_ptr_d = BID_W'(bank_ptr_inc(32'(wr_ptr_q), NBANK));
      end
      // The write bank is EMPTY and the read bank FULL, so they never alias.
      if (rd_fire) begin
        rd_sel_d = rd_ptr_q;
        if (rd_last_i) begin
          bank_st_d[rd_ptr_q] = BUF_EMPTY;
          rd_ptr_d = BID_W'(bank_ptr_inc(32'(rd_ptr_q), NBANK));
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NBANK; i++) bank_st_q[i] <= BUF_EMPTY;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      rd_sel_q       <= '0;
      rd_ret_valid_q <= 1'b0;
      have_data_q    <= 1'b0;
    end else begin
      bank_st_q      <= bank_st_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      rd_sel_q       <= rd_sel_d;
      rd_ret_valid_q <= rd_ret_valid_d;
      have_data_q    <= have_data_d;
    end
  end

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    assign bank_full_o[b] = (bank_st_q[b] == BUF_FULL);

    buf_bank_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_ram (
      .clk       (clk),
      .wr_en_i   (wr_fire && (wr_ptr_q == BID_W'(b))),
      .wr_addr_i (wr_addr_i),
      .wr_data_i (wr_data_i),
      .rd_en_i   (rd_fire && (rd_ptr_q == BID_W'(b))),
      .rd_addr_i (rd_addr_i),
      .rd_data_o (ram_rdata[b])
    );
  end

  // The RAM read registers are unreset; mask them until a read has returned
  // since reset so the output starts at zero.
  assign rd_ret_valid_o = rd_ret_valid_q;
  assign rd_ret_data_o  = have_data_q ? ram_rdata[rd_sel_q] : '0;

endmodule

// File: tb/tb_a_pingpong_buf.sv
// Directed bench for a_pingpong_buf: 2-bank, 1-bank and 3-bank instances
// sharing one clock and reset.
module tb_a_pingpong_buf;

  logic clk, rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  // u0: NBANK=2 DEPTH=64
  logic        fl0, wv0, wl0, rv0, rl0, wrdy0, ravl0, rrv0;
  logic [5:0]  wa0, ra0;
  logic [15:0] wd0, rrd0;
  logic [1:0]  bf0;
  // u1: NBANK=1 DEPTH=64
  logic        fl1, wv1, wl1, rv1, rl1, wrdy1, ravl1, rrv1;
  logic [5:0]  wa1, ra1;
  logic [15:0] wd1, rrd1;
  logic [0:0]  bf1;
  // u2: NBANK=3 DEPTH=8
  logic        fl2, wv2, wl2, rv2, rl2, wrdy2, ravl2, rrv2;
  logic [2:0]  wa2, ra2;
  logic [15:0] wd2, rrd2;
  logic [2:0]  bf2;

  a_pingpong_buf #(.DATA_W(16), .DEPTH(64), .NBANK(2)) u0 (
    .clk(clk), .rst_n(rst_n), .flush_i(fl0), .wr_valid_i(wv0), .wr_ready_o(wrdy0),
    .wr_addr_i(wa0), .wr_data_i(wd0), .wr_last_i(wl0), .rd_avail_o(ravl0),
    .rd_valid_i(rv0), .rd_addr_i(ra0), .rd_last_i(rl0), .rd_ret_valid_o(rrv0),
    .rd_ret_data_o(rrd0), .bank_full_o(bf0));

  a_pingpong_buf #(.DATA_W(16), .DEPTH(64), .NBANK(1)) u1 (
    .clk(clk), .rst_n(rst_n), .flush_i(fl1), .wr_valid_i(wv1), .wr_ready_o(wrdy1),
    .wr_addr_i(wa1), .wr_data_i(wd1), .wr_last_i(wl1), .rd_avail_o(ravl1),
    .rd_valid_i(rv1), .rd_addr_i(ra1), .rd_last_i(rl1), .rd_ret_valid_o(rrv1),
    .rd_ret_data_o(rrd1), .bank_full_o(bf1));

  a_pingpong_buf #(.DATA_W(16), .DEPTH(8), .NBANK(3)) u2 (
    .clk(clk), .rst_n(rst_n), .flush_i(fl2), .wr_valid_i(wv2), .wr_ready_o(wrdy2),
    .wr_addr_i(wa2), .wr_data_i(wd2), .wr_last_i(wl2), .rd_avail_o(ravl2),
    .rd_valid_i(rv2), .rd_addr_i(ra2), .rd_last_i(rl2), .rd_ret_valid_o(rrv2),
    .rd_ret_data_o(rrd2), .bank_full_o(bf2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fill0(input int base);
    for (int a = 0; a < 64; a++) begin
      wv0 = 1'b1; wa0 = 6'(a); wd0 = 16'(base + a); wl0 = (a == 63);
      tick();
    end
    wv0 = 1'b0; wl0 = 1'b0;
  endtask

  task automatic fill1(input int base);
    for (int a = 0; a < 64; a++) begin
      wv1 = 1'b1; wa1 = 6'(a); wd1 = 16'(base + a); wl1 = (a == 63);
      tick();
    end
    wv1 = 1'b0; wl1 = 1'b0;
  endtask

  task automatic fill2(input int k);
    for (int a = 0; a < 8; a++) begin
      wv2 = 1'b1; wa2 = 3'(a); wd2 = 16'(k * 16 + a); wl2 = (a == 7);
      tick();
    end
    wv2 = 1'b0; wl2 = 1'b0;
  endtask

  task automatic drain2(input int k);
    for (int a = 0; a < 8; a++) begin
      rv2 = 1'b1; ra2 = 3'(a); rl2 = (a == 7);
      tick();
      chk("nb3_rd_valid", 32'(rrv2), 1);
      chk("nb3_rd_data", 32'(rrd2), k * 16 + a);
    end
    rv2 = 1'b0; rl2 = 1'b0;
  endtask

  initial begin
    int kf, kd;
    logic [2:0] ef;
    rst_n = 1'b0;
    {fl0, wv0, wl0, rv0, rl0} = '0; wa0 = '0; ra0 = '0; wd0 = '0;
    {fl1, wv1, wl1, rv1, rl1} = '0; wa1 = '0; ra1 = '0; wd1 = '0;
    {fl2, wv2, wl2, rv2, rl2} = '0; wa2 = '0; ra2 = '0; wd2 = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // reset / idle state
    chk("rst_wr_ready", 32'(wrdy0), 1);
    chk("rst_rd_avail", 32'(ravl0), 0);
    chk("rst_bank_full", 32'(bf0), 0);
    chk("rst_ret_valid", 32'(rrv0), 0);
    chk("rst_ret_data", 32'(rrd0), 0);
    chk("rst_nb1_ready", 32'(wrdy1), 1);
    chk("rst_nb3_full", 32'(bf2), 0);

    // fill bank0, read one word
    fill0('h100);
    chk("fill0_full", 32'(bf0), 'b01);
    chk("fill0_avail", 32'(ravl0), 1);
    chk("fill0_ready", 32'(wrdy0), 1);
    rv0 = 1'b1; ra0 = 6'd5;
    tick();
    rv0 = 1'b0;
    chk("rd5_valid", 32'(rrv0), 1);
    chk("rd5_data", 32'(rrd0), 'h105);
    tick();
    chk("idle_valid", 32'(rrv0), 0);
    chk("idle_hold", 32'(rrd0), 'h105);

    // both banks full: back-pressure, dropped write, release, refill
    fill0('h200);
    chk("both_full", 32'(bf0), 'b11);
    chk("both_ready", 32'(wrdy0), 0);
    wv0 = 1'b1; wa0 = 6'd0; wd0 = 16'h3AA; wl0 = 1'b1;
    tick();
    wv0 = 1'b0; wl0 = 1'b0;
    chk("drop_full", 32'(bf0), 'b11);
    chk("drop_ready", 32'(wrdy0), 0);
    rv0 = 1'b1; ra0 = 6'd0;
    tick();
    chk("drop_nocorrupt", 32'(rrd0), 'h100);
    ra0 = 6'd63; rl0 = 1'b1;
    tick();
    rv0 = 1'b0; rl0 = 1'b0;
    chk("rel0_data", 32'(rrd0), 'h13F);
    chk("rel0_full", 32'(bf0), 'b10);
    chk("rel0_ready", 32'(wrdy0), 1);
    chk("rel0_avail", 32'(ravl0), 1);
    // refill bank0; its commit coincides with release of bank1
    for (int a = 0; a < 64; a++) begin
      wv0 = 1'b1; wa0 = 6'(a); wd0 = 16'('h300 + a); wl0 = (a == 63);
      if (a == 63) begin rv0 = 1'b1; ra0 = 6'd7; rl0 = 1'b1; end
      tick();
    end
    {wv0, wl0, rv0, rl0} = '0;
    chk("xy_full", 32'(bf0), 'b01);
    chk("xy_rd_data", 32'(rrd0), 'h207);
    rv0 = 1'b1; ra0 = 6'd9; rl0 = 1'b1;
    tick();
    rv0 = 1'b0; rl0 = 1'b0;
    chk("refill_data", 32'(rrd0), 'h309);
    chk("empty_full", 32'(bf0), 0);
    chk("empty_avail", 32'(ravl0), 0);

    // NBANK=1: release and write in the same cycle
    fill1('h400);
    chk("nb1_full", 32'(bf1), 1);
    chk("nb1_ready", 32'(wrdy1), 0);
    rv1 = 1'b1; ra1 = 6'd63; rl1 = 1'b1;
    wv1 = 1'b1; wa1 = 6'd0; wd1 = 16'h5AA; wl1 = 1'b1;
    tick();
    {rv1, rl1, wv1, wl1} = '0;
    chk("nb1_rel_data", 32'(rrd1), 'h43F);
    chk("nb1_wr_rejected", 32'(bf1), 0);
    chk("nb1_ready_rise", 32'(wrdy1), 1);
    // retry, with a read of the committing bank in the same cycle
    wv1 = 1'b1; wa1 = 6'd0; wd1 = 16'h5AA; wl1 = 1'b1;
    rv1 = 1'b1; ra1 = 6'd1;
    tick();
    {rv1, wv1, wl1} = '0;
    chk("nb1_retry_full", 32'(bf1), 1);
    chk("nb1_unhonoured_valid", 32'(rrv1), 0);
    chk("nb1_unhonoured_hold", 32'(rrd1), 'h43F);
    rv1 = 1'b1; ra1 = 6'd0;
    tick();
    chk("nb1_new_data", 32'(rrd1), 'h5AA);
    ra1 = 6'd1; rl1 = 1'b1;
    tick();
    rv1 = 1'b0; rl1 = 1'b0;
    chk("nb1_old_data", 32'(rrd1), 'h401);
    chk("nb1_released", 32'(bf1), 0);

    // NBANK=3: unhonoured read on empty, then fill/drain with wrap
    rv2 = 1'b1; ra2 = 3'd0;
    tick();
    rv2 = 1'b0;
    chk("nb3_empty_valid", 32'(rrv2), 0);
    chk("nb3_empty_data", 32'(rrd2), 0);
    kf = 0; kd = 0; ef = '0;
    for (int r = 0; r < 8; r++) begin
      fill2(kf);
      ef[kf % 3] = 1'b1;
      kf++;
      chk("nb3_fill_full", 32'(bf2), 32'(ef));
      if (kf - kd == 3) begin
        chk("nb3_backpressure", 32'(wrdy2), 0);
        drain2(kd);
        ef[kd % 3] = 1'b0;
        kd++;
        chk("nb3_drain_full", 32'(bf2), 32'(ef));
      end
    end
    while (kd < kf) begin
      drain2(kd);
      ef[kd % 3] = 1'b0;
      kd++;
      chk("nb3_tail_full", 32'(bf2), 32'(ef));
    end

    // flush with concurrent commit and read (both pointers sit at 1 here)
    fill0('h600);
    chk("pre_flush_full", 32'(bf0), 'b10);
    rv0 = 1'b1; ra0 = 6'd2;
    tick();
    chk("flush_cycle_valid", 32'(rrv0), 1);
    chk("flush_cycle_data", 32'(rrd0), 'h602);
    fl0 = 1'b1; wv0 = 1'b1; wa0 = 6'd0; wd0 = 16'hBAD; wl0 = 1'b1;
    ra0 = 6'd3; rl0 = 1'b1;
    tick();
    {fl0, wv0, wl0, rv0, rl0} = '0;
    chk("flush_full", 32'(bf0), 0);
    chk("flush_valid", 32'(rrv0), 0);
    chk("flush_ready", 32'(wrdy0), 1);
    chk("flush_avail", 32'(ravl0), 0);
    fill0('h700);
    chk("flush_wptr0", 32'(bf0), 'b01);
    chk("flush_rptr0", 32'(ravl0), 1);

    // async reset mid-fill with a read in flight
    wv0 = 1'b1; wa0 = 6'd0; wd0 = 16'h800;
    rv0 = 1'b1; ra0 = 6'd4;
    tick();
    chk("prerst_valid", 32'(rrv0), 1);
    chk("prerst_data", 32'(rrd0), 'h704);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_full", 32'(bf0), 0);
    chk("arst_ready", 32'(wrdy0), 1);
    chk("arst_avail", 32'(ravl0), 0);
    chk("arst_valid", 32'(rrv0), 0);
    chk("arst_data", 32'(rrd0), 0);
    {wv0, rv0} = '0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_full", 32'(bf0), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
